rx_mac_byte_packer: RTL and testbench



---
 rtl/rx_port_pkg.sv | 21 ++
 rtl/rx_word_fifo.sv | 46 ++++
 rtl/rx_mac_byte_packer.sv | 171 +++++++++++++++++
 tb/tb_rx_mac_byte_packer.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_port_pkg.sv
// Shared types for the receive-side port path: packer FSM states, speed codes
// and the drop-counter ceiling.
package rx_port_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PACK,
    DISCARD,
    ABORT_PEND
  } pack_state_e;

  typedef enum logic [1:0] {
    SPEED_10M  = 2'b00,
    SPEED_100M = 2'b01,
    SPEED_1G   = 2'b10,
    SPEED_10G  = 2'b11
  } port_speed_e;

  localparam logic [15:0] DROP_CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/rx_word_fifo.sv
// Synchronous show-ahead word FIFO: dout always presents the head entry.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module rx_word_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/rx_mac_byte_packer.sv
// Packs the MAC byte stream of one port into wide AXI-Stream words, absorbing
// ready stalls in a small FIFO and truncating or dropping frames that overflow it.
module rx_mac_byte_packer
  import rx_port_pkg::*;
#(
  parameter int PORT_NUM            = 4,
  parameter int PORT_MNG_DATA_WIDTH = 8,
  parameter int CROSS_DATA_WIDTH    = PORT_MNG_DATA_WIDTH * PORT_NUM,
  parameter int FIFO_DEPTH          = 4
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_mac_port_link,
  input  logic [1:0]                     i_mac_port_speed,
  input  logic [PORT_MNG_DATA_WIDTH-1:0] i_mac_rx_data,
  input  logic                           i_mac_rx_valid,
  input  logic                           i_mac_rx_last,
  input  logic                           i_mac_rx_crcerr,
  output logic                           o_mac_cross_port_link,
  output logic [1:0]                     o_mac_cross_port_speed,
  output logic [CROSS_DATA_WIDTH:0]      o_mac_cross_port_axi_data,
  output logic [CROSS_DATA_WIDTH/8-1:0]  o_mac_cross_axi_data_keep,
  output logic                           o_mac_cross_axi_data_valid,
  input  logic                           i_mac_cross_axi_data_ready,
  output logic                           o_mac_cross_axi_data_last,
  output logic [15:0]                    o_port_rx_drop_cnt
);

  localparam int KW    = CROSS_DATA_WIDTH / 8;
  localparam int FW    = CROSS_DATA_WIDTH + 1 + KW + 1;
  localparam int CNT_W = $clog2(PORT_NUM);
  localparam logic [FW-1:0] TERM_WORD =
    {1'b1, {{(KW-1){1'b0}}, 1'b1}, 1'b1, {CROSS_DATA_WIDTH{1'b0}}};

  pack_state_e                 state;
  port_speed_e                 speed_q;
  logic                        link_q;
  logic [CROSS_DATA_WIDTH-1:0] acc_data;
  logic [CNT_W-1:0]            byte_cnt;
  logic                        frame_started;
  logic                        term_owed;
  logic [15:0]                 drop_cnt;

  logic [CROSS_DATA_WIDTH-1:0] word_data;
  logic [KW-1:0]               word_keep;
  logic                        byte_in;
  logic                        word_done;
  logic                        pack_push;
  logic                        term_push;
  logic                        fifo_push;
  logic [FW-1:0]               fifo_din;
  logic [FW-1:0]               fifo_dout;
  logic                        fifo_full;
  logic                        fifo_empty;
  logic                        fifo_pop;
  logic                        fifo_room;
  logic                        drop_evt;

  // Output handshake: a word transfers on a cycle where valid and ready are both
  // high; while valid is high and ready low, data/keep/last hold the FIFO head.
  assign fifo_pop  = ~fifo_empty & i_mac_cross_axi_data_ready;
  assign fifo_room = ~fifo_full | fifo_pop;

  assign byte_in   = i_mac_rx_valid & i_mac_port_link;
  assign word_done = byte_in & (i_mac_rx_last | (byte_cnt == CNT_W'(PORT_NUM - 1)));
  assign pack_push = word_done & ((state == IDLE) | (state == PACK));
  assign term_push = (state == ABORT_PEND);
  assign fifo_push = (pack_push | term_push) & fifo_room;
  assign fifo_din  = term_push ? TERM_WORD
                   : {i_mac_rx_last, word_keep, i_mac_rx_last & i_mac_rx_crcerr, word_data};

  always_comb begin
    word_data = acc_data;
    word_data[int'(byte_cnt)*PORT_MNG_DATA_WIDTH +: PORT_MNG_DATA_WIDTH] = i_mac_rx_data;
    for (int k = 0; k < KW; k++) word_keep[k] = (k <= int'(byte_cnt));
  end

  always_comb begin
    drop_evt = 1'b0;
    case (state)
      IDLE:       drop_evt = byte_in & i_mac_rx_last & ~fifo_room;
      PACK:       drop_evt = ~i_mac_port_link | (word_done & ~fifo_room);
      ABORT_PEND: drop_evt = byte_in;
      default:    drop_evt = 1'b0;
    endcase
  end

  // acc_data is kept zero outside PACK so unused byte lanes of a short word read 0.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state         <= IDLE;
      speed_q       <= SPEED_10M;
      link_q        <= 1'b0;
      acc_data      <= '0;
      byte_cnt      <= '0;
      frame_started <= 1'b0;
      term_owed     <= 1'b0;
      drop_cnt      <= '0;
    end else begin
      link_q  <= i_mac_port_link;
      speed_q <= port_speed_e'(i_mac_port_speed);
      if (drop_evt && drop_cnt != DROP_CNT_MAX) drop_cnt <= drop_cnt + 16'd1;

      case (state)
        IDLE: begin
          frame_started <= 1'b0;
          if (byte_in && !i_mac_rx_last) begin
            acc_data <= word_data;
            byte_cnt <= CNT_W'(1);
            state    <= PACK;
          end
        end
        PACK: begin
          if (!i_mac_port_link) begin
            acc_data  <= '0;
            byte_cnt  <= '0;
            term_owed <= frame_started;
            state     <= frame_started ? ABORT_PEND : IDLE;
          end else if (word_done) begin
            acc_data <= '0;
            byte_cnt <= '0;
            if (fifo_room) begin
              frame_started <= 1'b1;
              if (i_mac_rx_last) state <= IDLE;
            end else begin
              term_owed <= frame_started;
              if (i_mac_rx_last) state <= frame_started ? ABORT_PEND : IDLE;
              else               state <= DISCARD;
            end
          end else if (byte_in) begin
            acc_data <= word_data;
            byte_cnt <= byte_cnt + 1'b1;
          end
        end
        DISCARD: begin
          if (byte_in && i_mac_rx_last) state <= term_owed ? ABORT_PEND : IDLE;
        end
        ABORT_PEND: begin
          // A frame arriving here is dropped whole; the terminator may still be owed.
          if (fifo_room) term_owed <= 1'b0;
          if (byte_in && !i_mac_rx_last) state <= DISCARD;
          else if (fifo_room)            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  rx_word_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (i_clk),
    .rst   (i_rst),
    .push  (fifo_push),
    .din   (fifo_din),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign o_mac_cross_port_link      = link_q;
  assign o_mac_cross_port_speed     = speed_q;
  assign o_mac_cross_axi_data_valid = ~fifo_empty;
  assign o_mac_cross_port_axi_data  = fifo_empty ? '0 : fifo_dout[CROSS_DATA_WIDTH:0];
  assign o_mac_cross_axi_data_keep  = fifo_empty ? '0 : fifo_dout[CROSS_DATA_WIDTH+KW:CROSS_DATA_WIDTH+1];
  assign o_mac_cross_axi_data_last  = fifo_empty ? 1'b0 : fifo_dout[FW-1];
  assign o_port_rx_drop_cnt         = drop_cnt;

endmodule

// File: tb/tb_rx_mac_byte_packer.sv
// Self-checking bench for rx_mac_byte_packer: random frames and stalls checked
// cycle by cycle against a frame-level model of the output word stream.
module tb_rx_mac_byte_packer;

  localparam int PORT_NUM   = 4;
  localparam int CW         = 32;
  localparam int FIFO_DEPTH = 4;
  localparam int KW         = CW / 8;
  localparam int W          = CW + 1 + KW + 1;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          i_link;
  logic [1:0]    i_speed;
  logic [7:0]    i_data;
  logic          i_valid;
  logic          i_last;
  logic          i_crcerr;
  logic          i_ready;
  logic          o_link;
  logic [1:0]    o_speed;
  logic [CW:0]   o_data;
  logic [KW-1:0] o_keep;
  logic          o_valid;
  logic          o_last;
  logic [15:0]   o_drop;

  always #2 i_clk = ~i_clk;

  rx_mac_byte_packer #(
    .PORT_NUM            (PORT_NUM),
    .PORT_MNG_DATA_WIDTH (8),
    .CROSS_DATA_WIDTH    (CW),
    .FIFO_DEPTH          (FIFO_DEPTH)
  ) dut (
    .i_clk                      (i_clk),
    .i_rst                      (i_rst),
    .i_mac_port_link            (i_link),
    .i_mac_port_speed           (i_speed),
    .i_mac_rx_data              (i_data),
    .i_mac_rx_valid             (i_valid),
    .i_mac_rx_last              (i_last),
    .i_mac_rx_crcerr            (i_crcerr),
    .o_mac_cross_port_link      (o_link),
    .o_mac_cross_port_speed     (o_speed),
    .o_mac_cross_port_axi_data  (o_data),
    .o_mac_cross_axi_data_keep  (o_keep),
    .o_mac_cross_axi_data_valid (o_valid),
    .i_mac_cross_axi_data_ready (i_ready),
    .o_mac_cross_axi_data_last  (o_last),
    .o_port_rx_drop_cnt         (o_drop)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Model: exp_q is the expected FIFO content, words encoded {last, keep, crcerr, data}.
  logic [W-1:0] exp_q[$];
  logic [7:0]   m_bytes[$];
  bit           m_in, m_skip, m_owed, m_started;
  logic [15:0]  m_drop;
  logic         prev_link;
  logic [1:0]   prev_speed;
  logic [1:0]   cur_speed;

  int           cyc;
  int           first_valid_cyc;
  int           dut_words;
  logic [W-1:0] last_pop;

  function automatic logic [W-1:0] mk_word(input bit last, input bit crc);
    logic [CW-1:0] d;
    logic [KW-1:0] k;
    d = '0;
    k = '0;
    for (int i = 0; i < m_bytes.size(); i++) begin
      d[8*i +: 8] = m_bytes[i];
      k[i] = 1'b1;
    end
    return {last, k, crc, d};
  endfunction

  function automatic logic [W-1:0] term_word();
    logic [KW-1:0] k;
    k = '0;
    k[0] = 1'b1;
    return {1'b1, k, 1'b1, {CW{1'b0}}};
  endfunction

  task automatic model_drop_inc();
    if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
  endtask

  task automatic model_clear();
    exp_q.delete();
    m_bytes.delete();
    m_in = 0; m_skip = 0; m_owed = 0; m_started = 0;
    m_drop = '0;
    prev_link = 1'b0;
    prev_speed = 2'b00;
  endtask

  // One clock cycle: scoreboard compare at the negedge, drive, model, advance.
  task automatic step(input logic lk, input logic v, input logic [7:0] d,
                      input logic l, input logic c, input logic r);
    bit pop, room, pending;
    logic [W-1:0] head;
    head = {o_last, o_keep, o_data};
    n_cmp++;
    if (o_valid !== (exp_q.size() != 0)) begin
      n_fail++;
      $display("FAIL valid cyc=%0d got=%b want=%b", cyc, o_valid, exp_q.size() != 0);
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      if (head !== exp_q[0]) begin
        n_fail++;
        $display("FAIL word cyc=%0d got=%h want=%h", cyc, head, exp_q[0]);
      end
    end
    n_cmp++;
    if (o_drop !== m_drop) begin
      n_fail++;
      $display("FAIL drop_cnt cyc=%0d got=%0d want=%0d", cyc, o_drop, m_drop);
    end
    n_cmp++;
    if (o_link !== prev_link || o_speed !== prev_speed) begin
      n_fail++;
      $display("FAIL link_speed cyc=%0d got=%b/%b want=%b/%b", cyc, o_link, o_speed, prev_link, prev_speed);
    end
    if (o_valid === 1'b1 && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (o_valid === 1'b1 && r) begin
      dut_words++;
      last_pop = head;
    end

    i_link = lk; i_speed = cur_speed; i_valid = v; i_data = d; i_last = l; i_crcerr = c; i_ready = r;

    pop     = r && (exp_q.size() != 0);
    room    = (exp_q.size() < FIFO_DEPTH) || pop;
    pending = m_owed && !m_in && !m_skip;
    if (pop) void'(exp_q.pop_front());
    if (pending && room) begin
      exp_q.push_back(term_word());
      m_owed = 0;
    end
    if (m_in && !lk) begin
      model_drop_inc();
      if (m_started) m_owed = 1;
      m_in = 0;
      m_bytes.delete();
    end else if (lk && v) begin
      if (m_skip) begin
        if (l) m_skip = 0;
      end else if (pending) begin
        model_drop_inc();
        if (!l) m_skip = 1;
      end else begin
        if (!m_in) begin m_in = 1; m_started = 0; end
        m_bytes.push_back(d);
        if (m_bytes.size() == PORT_NUM || l) begin
          if (room) begin
            exp_q.push_back(mk_word(l, l && c));
            if (l) m_in = 0; else m_started = 1;
          end else begin
            model_drop_inc();
            m_in = 0;
            if (m_started) m_owed = 1;
            if (!l) m_skip = 1;
          end
          m_bytes.delete();
        end
      end
    end
    prev_link = lk;
    prev_speed = cur_speed;
    cyc++;
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  // rmode: 0 ready high, 1 ready low, 2 random ready. drop_at<0: link stays up.
  task automatic send_frame(input int len, input bit crc, input int rmode, input int drop_at);
    logic r;
    for (int i = 0; i < len; i++) begin
      r = (rmode == 0) ? 1'b1 : (rmode == 1) ? 1'b0 : ($urandom_range(0, 3) != 0);
      step((drop_at < 0) || (i < drop_at), 1'b1, 8'($urandom_range(0, 255)),
           i == len - 1, crc, r);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 40; i++) step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic mark();
    first_valid_cyc = -1;
    dut_words = 0;
    last_pop = '0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge i_clk);
    n_cmp++;
    if (o_valid !== 1'b0 || o_last !== 1'b0 || o_data !== '0 || o_keep !== '0) begin
      n_fail++;
      $display("FAIL reset_axi got v=%b l=%b d=%h k=%h want all 0", o_valid, o_last, o_data, o_keep);
    end
    n_cmp++;
    if (o_drop !== 16'd0 || o_link !== 1'b0 || o_speed !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_misc got drop=%0d link=%b speed=%b want 0", o_drop, o_link, o_speed);
    end
    i_rst = 1'b0;
  endtask

  task automatic test_full_frame();
    int c0;
    logic [15:0] d0;
    d0 = m_drop;
    mark();
    c0 = cyc;
    send_frame(64, 1'b0, 0, -1);
    drain();
    n_cmp++;
    if (first_valid_cyc - c0 != 4) begin
      n_fail++;
      $display("FAIL full_latency got=%0d want=4", first_valid_cyc - c0);
    end
    n_cmp++;
    if (dut_words != 16 || last_pop[W-1] !== 1'b1 || last_pop[CW] !== 1'b0 || last_pop[W-2:CW+1] !== 4'hF) begin
      n_fail++;
      $display("FAIL full_words got n=%0d last=%h want n=16 last=1 keep=f crc=0", dut_words, last_pop);
    end
    n_cmp++;
    if (o_drop !== d0) begin
      n_fail++;
      $display("FAIL full_drop got=%0d want=%0d", o_drop, d0);
    end
  endtask

  task automatic test_crc_frame();
    mark();
    send_frame(61, 1'b1, 0, -1);
    drain();
    n_cmp++;
    if (dut_words != 16 || last_pop[W-2:CW+1] !== 4'h1 || last_pop[CW] !== 1'b1 || last_pop[W-1] !== 1'b1) begin
      n_fail++;
      $display("FAIL crc_frame got n=%0d last=%h want n=16 keep=1 crc=1 last=1", dut_words, last_pop);
    end
  endtask

  task automatic test_single_byte();
    logic [W-1:0] want;
    want = {1'b1, 4'h1, 1'b0, 32'h000000A5};
    mark();
    step(1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b1);
    drain();
    n_cmp++;
    if (dut_words != 1 || last_pop !== want) begin
      n_fail++;
      $display("FAIL single_byte got n=%0d w=%h want n=1 w=%h", dut_words, last_pop, want);
    end
  endtask

  task automatic test_overflow_truncate();
    logic [15:0] d0;
    d0 = m_drop;
    mark();
    send_frame(64, 1'b0, 1, -1);
    drain();
    n_cmp++;
    if (dut_words != 5 || last_pop !== term_word()) begin
      n_fail++;
      $display("FAIL overflow_term got n=%0d last=%h want n=5 last=%h", dut_words, last_pop, term_word());
    end
    n_cmp++;
    if (o_drop !== d0 + 16'd1) begin
      n_fail++;
      $display("FAIL overflow_drop got=%0d want=%0d", o_drop, d0 + 16'd1);
    end
  endtask

  task automatic test_silent_drop();
    logic [15:0] d0;
    d0 = m_drop;
    mark();
    for (int i = 0; i < FIFO_DEPTH; i++) step(1'b1, 1'b1, 8'(i + 1), 1'b1, 1'b0, 1'b0);
    send_frame(20, 1'b0, 1, -1);
    drain();
    n_cmp++;
    if (dut_words != FIFO_DEPTH || last_pop[CW] !== 1'b0) begin
      n_fail++;
      $display("FAIL silent_words got n=%0d last=%h want n=%0d no crc", dut_words, last_pop, FIFO_DEPTH);
    end
    n_cmp++;
    if (o_drop !== d0 + 16'd1) begin
      n_fail++;
      $display("FAIL silent_drop got=%0d want=%0d", o_drop, d0 + 16'd1);
    end
  endtask

  task automatic test_link_drop();
    logic [15:0] d0;
    d0 = m_drop;
    mark();
    send_frame(20, 1'b0, 0, 10);
    repeat (3) step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    send_frame(8, 1'b0, 0, -1);
    drain();
    n_cmp++;
    if (dut_words != 5 || last_pop[W-1] !== 1'b1 || last_pop[CW] !== 1'b0 || last_pop[W-2:CW+1] !== 4'hF) begin
      n_fail++;
      $display("FAIL link_words got n=%0d last=%h want n=5 clean last", dut_words, last_pop);
    end
    n_cmp++;
    if (o_drop !== d0 + 16'd1) begin
      n_fail++;
      $display("FAIL link_drop got=%0d want=%0d", o_drop, d0 + 16'd1);
    end
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 40; f++) begin
      cur_speed = 2'($urandom_range(0, 3));
      send_frame($urandom_range(1, 24), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 2) == 0) ? 1 : 2,
                 ($urandom_range(0, 9) == 0) ? $urandom_range(1, 6) : -1);
      repeat ($urandom_range(0, 2)) step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
    end
    drain();
  endtask

  task automatic test_reset_mid_frame();
    send_frame(3, 1'b0, 1, -1);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
    i_rst = 1'b1;
    #1;
    n_cmp++;
    if (o_valid !== 1'b0 || o_drop !== 16'd0 || o_link !== 1'b0 || o_data !== '0) begin
      n_fail++;
      $display("FAIL midreset got v=%b drop=%0d link=%b d=%h want 0", o_valid, o_drop, o_link, o_data);
    end
    i_valid = 1'b0;
    model_clear();
    @(negedge i_clk);
    i_rst = 1'b0;
    mark();
    send_frame(9, 1'b0, 0, -1);
    drain();
    n_cmp++;
    if (dut_words != 3) begin
      n_fail++;
      $display("FAIL midreset_after got n=%0d want=3", dut_words);
    end
  endtask

  initial begin
    i_rst = 1'b1; i_link = 1'b0; i_speed = 2'b00; i_data = '0; i_valid = 1'b0;
    i_last = 1'b0; i_crcerr = 1'b0; i_ready = 1'b0;
    cur_speed = 2'b10;
    cyc = 0;
    model_clear();
    mark();
    test_reset();
    test_full_frame();
    test_crc_frame();
    test_single_byte();
    test_overflow_truncate();
    test_silent_drop();
    test_link_drop();
    test_back_to_back();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
